// File: rtl/hprime_mac_engine.sv
// Time-multiplexed hidden-layer MAC: one feature per handshake, N_OUT parallel
// lanes against a run-time loadable weight/bias memory, saturated result out.
module hprime_mac_engine #(
  parameter  int N_IN   = 41,
  parameter  int N_OUT  = 8,
  parameter  int DATA_W = 32,
  parameter  int FRAC_W = 16,
  localparam int OW     = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int IW     = $clog2(N_IN + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [DATA_W-1:0]       x_data,
  input  logic                    w_we,
  input  logic [OW-1:0]           w_out_idx,
  input  logic [IW-1:0]           w_in_idx,
  input  logic [DATA_W-1:0]       w_data,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] hprime_flat,
  output logic [N_OUT-1:0]        sat_flags
);

  localparam int AW = DATA_W + FRAC_W + IW;
  localparam int PW = (2 * DATA_W > AW) ? 2 * DATA_W : AW;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state, state_next;
  logic [IW-1:0]            cnt;
  logic signed [DATA_W-1:0] wmem [N_OUT][N_IN+1];
  logic signed [AW-1:0]     acc [N_OUT];
  logic signed [AW-1:0]     acc_sum [N_OUT];
  logic [DATA_W-1:0]        lane_sat [N_OUT];
  logic [N_OUT-1:0]         lane_clamp;
  logic                     fire, last, w_hit;

  assign fire  = x_valid && x_ready;
  assign last  = (state == IDLE && N_IN == 1) || (state == ACCUM && cnt == LAST_IDX);
  assign w_hit = w_we && (state == IDLE) && (int'(w_out_idx) < N_OUT) && (int'(w_in_idx) <= N_IN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state uses x_valid directly: x_ready is 1 whenever a transition on it matters.
  always_comb begin
    state_next = state;
    x_ready    = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        x_ready = 1'b1;
        if (x_valid) state_next = (N_IN == 1) ? DONE : ACCUM;
      end
      ACCUM: begin
        x_ready = 1'b1;
        if (x_valid && cnt == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Weight memory has no reset; reads below see the pre-write contents.
  always_ff @(posedge clock) begin
    if (w_hit) wmem[w_out_idx][w_in_idx] <= w_data;
  end

  always_comb begin : lanes
    logic signed [PW-1:0] x_ext, w_ext, prod, shifted;
    logic signed [AW-1:0] base;
    x_ext      = {{(PW-DATA_W){x_data[DATA_W-1]}}, x_data};
    w_ext      = '0;
    prod       = '0;
    shifted    = '0;
    base       = '0;
    lane_clamp = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      w_ext   = {{(PW-DATA_W){wmem[k][cnt][DATA_W-1]}}, wmem[k][cnt]};
      prod    = x_ext * w_ext;
      shifted = prod >>> FRAC_W;
      base    = (state == IDLE) ? {{(AW-DATA_W){wmem[k][N_IN][DATA_W-1]}}, wmem[k][N_IN]} : acc[k];
      acc_sum[k] = base + shifted[AW-1:0];
      if (acc_sum[k] > SAT_MAX) begin
        lane_sat[k]   = {1'b0, {(DATA_W-1){1'b1}}};
        lane_clamp[k] = 1'b1;
      end else if (acc_sum[k] < SAT_MIN) begin
        lane_sat[k]   = {1'b1, {(DATA_W-1){1'b0}}};
        lane_clamp[k] = 1'b1;
      end else begin
        lane_sat[k]   = acc_sum[k][DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      hprime_flat <= '0;
      sat_flags   <= '0;
      for (int unsigned k = 0; k < N_OUT; k++) acc[k] <= '0;
    end else if (fire) begin
      cnt <= last ? '0 : cnt + IW'(1);
      for (int unsigned k = 0; k < N_OUT; k++) acc[k] <= acc_sum[k];
      if (last) begin
        for (int unsigned k = 0; k < N_OUT; k++) hprime_flat[k*DATA_W +: DATA_W] <= lane_sat[k];
        sat_flags <= lane_clamp;
      end
    end
  end

endmodule

// File: tb/tb_hprime_mac_engine.sv
// Scoreboard bench for hprime_mac_engine: stimulus pushes model results,
// a negedge monitor compares whenever out_valid is presented.
module tb_hprime_mac_engine;

  localparam int N_IN   = 41;
  localparam int N_OUT  = 8;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;

  typedef struct {
    logic [N_OUT*DATA_W-1:0] h;
    logic [N_OUT-1:0]        f;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    x_valid = 1'b0;
  logic                    x_ready;
  logic [DATA_W-1:0]       x_data = '0;
  logic                    w_we = 1'b0;
  logic [2:0]              w_out_idx = '0;
  logic [5:0]              w_in_idx = '0;
  logic [DATA_W-1:0]       w_data = '0;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [N_OUT*DATA_W-1:0] hprime_flat;
  logic [N_OUT-1:0]        sat_flags;

  int     checks = 0;
  int     failures = 0;
  bit     bp_rand = 1'b0;
  exp_t   sbq[$];
  longint wm [N_OUT][N_IN+1];
  int     xs [N_IN];

  hprime_mac_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clock(clk), .reset(rst), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .w_we(w_we), .w_out_idx(w_out_idx), .w_in_idx(w_in_idx), .w_data(w_data),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .hprime_flat(hprime_flat), .sat_flags(sat_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: bias + sum of floor(x*w / 2^FRAC_W) in wide integers, then clamp.
  function automatic exp_t model();
    exp_t   e;
    longint acc;
    logic [63:0] bits;
    e.h = '0;
    e.f = '0;
    for (int k = 0; k < N_OUT; k++) begin
      acc = wm[k][N_IN];
      for (int i = 0; i < N_IN; i++) acc += (longint'(xs[i]) * wm[k][i]) >>> FRAC_W;
      if (acc > 64'sd2147483647) begin
        acc = 64'sd2147483647;
        e.f[k] = 1'b1;
      end else if (acc < -64'sd2147483648) begin
        acc = -64'sd2147483648;
        e.f[k] = 1'b1;
      end
      bits = acc;
      e.h[k*DATA_W +: DATA_W] = bits[31:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", hprime_flat);
      end else begin
        chk("hprime", hprime_flat, sbq[0].h);
        chk("sat_flags", sat_flags, sbq[0].f);
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic write_w(input int lane, input int idx, input logic [31:0] val);
    w_we = 1'b1;
    w_out_idx = 3'(lane);
    w_in_idx = 6'(idx);
    w_data = val;
    @(posedge clk); #1;
    w_we = 1'b0;
    if (idx <= N_IN) wm[lane][idx] = longint'(signed'(val));
  endtask

  task automatic load_all(input logic [31:0] w, input logic [31:0] b);
    for (int k = 0; k < N_OUT; k++)
      for (int i = 0; i <= N_IN; i++) write_w(k, i, (i == N_IN) ? b : w);
  endtask

  task automatic fill_x(input logic [31:0] v);
    for (int i = 0; i < N_IN; i++) xs[i] = v;
  endtask

  // Feeds n features of xs; a complete frame pushes its expected result first.
  task automatic send_frame(input int gap_max, input int n, input bit wr_first, input bit wr_accum);
    int t;
    logic [31:0] nv;
    nv = $urandom;
    if (n == N_IN) sbq.push_back(model());
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      x_valid = 1'b1;
      x_data = xs[i];
      if (i == 0 && wr_first) begin
        w_we = 1'b1; w_out_idx = 3'd0; w_in_idx = 6'd1; w_data = nv;
      end
      if (i == 5 && wr_accum) begin
        w_we = 1'b1; w_out_idx = 3'd0; w_in_idx = 6'd0; w_data = '0;
      end
      t = 0;
      @(negedge clk);
      while (!x_ready && t < 300) begin @(negedge clk); t++; end
      if (!x_ready) begin
        checks++;
        failures++;
        $display("FAIL x_handshake_timeout actual=%0d required=1", x_ready);
      end
      @(posedge clk); #1;
      x_valid = 1'b0;
      w_we = 1'b0;
      if (i == 0 && wr_first) wm[0][1] = longint'(signed'(nv));
      if (i == N_IN - 1) chk("latency_out_valid", out_valid, 1'b1);
    end
  endtask

  task automatic rand_weights();
    for (int k = 0; k < N_OUT; k++)
      for (int i = 0; i <= N_IN; i++)
        write_w(k, i, ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h0003FFFF) - 32'h0001FFFF);
  endtask

  initial begin
    #2;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_x_ready", x_ready, 1'b1);
    chk("reset_hprime", hprime_flat, '0);
    chk("reset_sat", sat_flags, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All ones: every lane 41.0
    load_all(32'h00010000, 32'h0);
    write_w(0, 50, 32'h12345678);
    fill_x(32'h00010000);
    send_frame(0, N_IN, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Back-pressure hold: outputs stable, features refused
    out_ready = 1'b0;
    send_frame(0, N_IN, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      x_valid = c[0];
      x_data = $urandom;
      @(negedge clk);
      chk("hold_x_ready", x_ready, 1'b0);
      chk("hold_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_busy", busy, 1'b0);
    send_frame(0, N_IN, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Abort after 20 features
    send_frame(0, 20, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_x_ready", x_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_hprime", hprime_flat, '0);
    chk("abort_sat", sat_flags, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(0, N_IN, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Lane 3 bias 0.5, lane 5 weights -1.0
    write_w(3, N_IN, 32'h00008000);
    for (int i = 0; i < N_IN; i++) write_w(5, i, 32'hFFFF0000);
    send_frame(0, N_IN, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Saturation both directions
    load_all(32'h7FFFFFFF, 32'h0);
    fill_x(32'h7FFFFFFF);
    send_frame(0, N_IN, 1'b0, 1'b0);
    @(posedge clk); #1;
    load_all(32'h80000000, 32'h0);
    send_frame(0, N_IN, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Random weights/features, gaps, back-pressure, ignored and same-cycle writes
    rand_weights();
    bp_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N_IN; i++)
        xs[i] = ($urandom_range(0, 5) == 0) ? $urandom : $urandom_range(0, 32'h000FFFFF) - 32'h0007FFFF;
      send_frame(3, N_IN, f == 2, f == 4);
      if (f == 3) begin
        bp_rand = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rand_weights();
        bp_rand = 1'b1;
      end
    end
    bp_rand = 1'b0;
    #1 out_ready = 1'b1;

    begin
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 500) begin @(posedge clk); t++; end
    end
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
